reg_xfer_seq: RTL and testbench

//  Micro-sequencer for the 3-register (A,B,C) bus-transfer datapath. Sits directly upstream of
//  the register/bus-mux stage: takes one transfer command per handshake and produces the bus mux

---
 rtl/reg_xfer_seq.sv | 218 +++++++++++++++++++++
 tb/tb_reg_xfer_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: micro-sequencer for the A/B/C register bus-transfer datapath.
// Accepts one transfer command per cmd_valid/cmd_ready handshake and steps the bus mux
// select (bus_sel), one-hot register loads (load_en {C,B,A}) and input-path select (in_sel).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only while idle)
//   cmd_op/cmd_src/cmd_dst           MOVE/SWAP/CLEAR/STEP, source A/B/C/tmp, destination A/B/C
//   bus_in                           bus mux output fed back for tmp capture
//   bus_sel, load_en, in_sel         datapath controls
//   tmp_q                            temp register, tied by the datapath to bus mux input 3
//   busy, done, err                  status; done/err are single-cycle pulses
module reg_xfer_seq #(
  parameter int unsigned W      = 4,
  parameter int unsigned SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [1:0]   cmd_src,
  input  logic [1:0]   cmd_dst,
  input  logic [W-1:0] bus_in,
  output logic [1:0]   bus_sel,
  output logic [2:0]   load_en,
  output logic         in_sel,
  output logic [W-1:0] tmp_q,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [1:0]       SEL_TMP  = 2'd3;

  typedef enum logic [1:0] {OP_MOVE = 2'd0, OP_SWAP = 2'd1, OP_CLEAR = 2'd2, OP_STEP = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SEL, S_ACT, S_FIN} state_e;

  // Action taken in the ACT cycle of one step.
  typedef struct packed {
    logic       cap;   // capture bus_in into tmp_q instead of loading a register
    logic [1:0] ld;    // register index to load
    logic       inc;   // load from the inc/dec path
    logic       last;  // final step of the command
  } act_t;

  // Bus select for a given step of a command.
  function automatic logic [1:0] sel_of(input op_e op, input logic [1:0] src,
                                        input logic [1:0] dst, input logic [1:0] step);
    logic [1:0] s;
    case (op)
      OP_MOVE:  s = src;
      OP_SWAP:  s = (step == 2'd0) ? src : ((step == 2'd1) ? dst : SEL_TMP);
      OP_CLEAR: s = SEL_TMP;
      default:  s = dst;
    endcase
    return s;
  endfunction

  // Action for a given step of a command.
  function automatic act_t act_of(input op_e op, input logic [1:0] src,
                                  input logic [1:0] dst, input logic [1:0] step);
    act_t a;
    a.cap  = 1'b0;
    a.ld   = dst;
    a.inc  = 1'b0;
    a.last = 1'b1;
    case (op)
      OP_SWAP: begin
        a.cap  = (step == 2'd0);
        a.ld   = (step == 2'd1) ? src : dst;
        a.last = (step == 2'd2);
      end
      OP_STEP: a.inc = 1'b1;
      default: ;
    endcase
    return a;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       dst_q, dst_d;
  logic [W-1:0]     tmp_d;
  logic [1:0]       bus_sel_q, bus_sel_d;
  logic [2:0]       load_en_q, load_en_d;
  logic             in_sel_q, in_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cmd_ready_q, cmd_ready_d;
  act_t             cur_c;
  logic             reject_c;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= 2'd0;
      cnt_q       <= '0;
      op_q        <= OP_MOVE;
      src_q       <= 2'd0;
      dst_q       <= 2'd0;
      tmp_q       <= '0;
      bus_sel_q   <= 2'd0;
      load_en_q   <= 3'd0;
      in_sel_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      tmp_q       <= tmp_d;
      bus_sel_q   <= bus_sel_d;
      load_en_q   <= load_en_d;
      in_sel_q    <= in_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they register in step.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    tmp_d       = tmp_q;
    bus_sel_d   = bus_sel_q;
    load_en_d   = 3'd0;
    in_sel_d    = 1'b1;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_ready_d = 1'b0;
    cur_c       = act_of(op_q, src_q, dst_q, step_q);
    reject_c    = (cmd_dst == 2'd3) ||
                  ((op_e'(cmd_op) == OP_SWAP) && ((cmd_src == 2'd3) || (cmd_src == cmd_dst)));

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          op_d        = op_e'(cmd_op);
          src_d       = cmd_src;
          dst_d       = cmd_dst;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (reject_c) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_SEL;
            step_d    = 2'd0;
            cnt_d     = SETTLE_C;
            bus_sel_d = sel_of(op_e'(cmd_op), cmd_src, cmd_dst, 2'd0);
            if (op_e'(cmd_op) == OP_CLEAR) begin
              tmp_d = '0;
            end
          end
        end
      end
      S_SEL: begin
        if (cnt_q == '0) begin
          state_d = S_ACT;
          if (!cur_c.cap) begin
            load_en_d = 3'b001 << cur_c.ld;
          end
          in_sel_d = ~cur_c.inc;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACT: begin
        if (cur_c.cap) begin
          tmp_d = bus_in;
        end
        if (cur_c.last) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d   = S_SEL;
          step_d    = step_q + 2'd1;
          cnt_d     = SETTLE_C;
          bus_sel_d = sel_of(op_q, src_q, dst_q, step_q + 2'd1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign bus_sel   = bus_sel_q;
  assign load_en   = load_en_q;
  assign in_sel    = in_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb_reg_xfer_seq: two sequencer instances (SETTLE=0 and SETTLE=3), each driving a small
// A/B/C register + bus mux datapath model. Expected results are queued at command accept and
// checked by a monitor when done pulses.
module tb_reg_xfer_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned S1 = 3;
  localparam logic [1:0] MOVE = 2'd0, SWAP = 2'd1, CLEAR = 2'd2, STEP = 2'd3;

  typedef struct {
    int           id;
    logic         e_err;
    logic [W-1:0] a, b, c, t;
    int           lat;
    int           nld;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid [2];
  logic         cmd_ready [2];
  logic [1:0]   cmd_op    [2];
  logic [1:0]   cmd_src   [2];
  logic [1:0]   cmd_dst   [2];
  logic [W-1:0] bus_in    [2];
  logic [1:0]   bus_sel   [2];
  logic [2:0]   load_en   [2];
  logic         in_sel    [2];
  logic [W-1:0] tmp_q     [2];
  logic         busy      [2];
  logic         done      [2];
  logic         err       [2];

  reg_xfer_seq #(.W(W), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_src(cmd_src[0]), .cmd_dst(cmd_dst[0]), .bus_in(bus_in[0]),
    .bus_sel(bus_sel[0]), .load_en(load_en[0]), .in_sel(in_sel[0]), .tmp_q(tmp_q[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  reg_xfer_seq #(.W(W), .SETTLE(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_src(cmd_src[1]), .cmd_dst(cmd_dst[1]), .bus_in(bus_in[1]),
    .bus_sel(bus_sel[1]), .load_en(load_en[1]), .in_sel(in_sel[1]), .tmp_q(tmp_q[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  // Datapath model: registers A/B/C, bus mux with tmp on input 3, inc path = bus + 1.
  logic [W-1:0] rf    [2][3];
  logic         pre_en[2];
  logic [W-1:0] pre_v [2][3];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      case (bus_sel[i])
        2'd0:    bus_in[i] = rf[i][0];
        2'd1:    bus_in[i] = rf[i][1];
        2'd2:    bus_in[i] = rf[i][2];
        default: bus_in[i] = tmp_q[i];
      endcase
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (pre_en[i])       rf[i][r] <= pre_v[i][r];
        else if (load_en[i][r]) rf[i][r] <= in_sel[i] ? bus_in[i] : W'(bus_in[i] + 1'b1);
      end
    end
  end

  // Scoreboard state and counters.
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;
  int   q_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   acc   [2] = '{0, 0};
  int   nld   [2] = '{0, 0};
  int   n_acc [2] = '{0, 0};
  int   n_done[2] = '{0, 0};

  int exp_bs[6] = '{0, 0, 2, 2, 3, 3};
  int exp_le[6] = '{0, 0, 0, 1, 0, 4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int lat_of(input int i, input logic [1:0] op, input logic e);
    int s;
    s = (i == 1) ? int'(S1) : 0;
    if (e) return 1;
    if (op == SWAP) return 3 * (2 + s) + 1;
    return 3 + s;
  endfunction

  // Cycle counter, accept time and load-pulse count per command.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (cmd_valid[i] && cmd_ready[i]) begin
        acc[i]   <= cyc;
        nld[i]   <= 0;
        n_acc[i] <= n_acc[i] + 1;
      end else if (load_en[i] != 3'd0) begin
        nld[i] <= nld[i] + 1;
      end
    end
  end

  // Monitor: per-cycle invariants and scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_load_en_onehot0", i), 32'($countones(load_en[i]) <= 1), 32'd1);
        chk($sformatf("u%0d_err_only_with_done", i), 32'(err[i] && !done[i]), 32'd0);
        if (done[i]) begin
          n_done[i] = n_done[i] + 1;
          q_n = (i == 0) ? sb0.size() : sb1.size();
          chk($sformatf("u%0d_done_has_expectation", i), 32'(q_n > 0), 32'd1);
          if (q_n > 0) begin
            if (i == 0) mon_e = sb0.pop_front();
            else        mon_e = sb1.pop_front();
            chk($sformatf("u%0d_cmd%0d_err", i, mon_e.id), 32'(err[i]), 32'(mon_e.e_err));
            chk($sformatf("u%0d_cmd%0d_A", i, mon_e.id), 32'(rf[i][0]), 32'(mon_e.a));
            chk($sformatf("u%0d_cmd%0d_B", i, mon_e.id), 32'(rf[i][1]), 32'(mon_e.b));
            chk($sformatf("u%0d_cmd%0d_C", i, mon_e.id), 32'(rf[i][2]), 32'(mon_e.c));
            chk($sformatf("u%0d_cmd%0d_tmp", i, mon_e.id), 32'(tmp_q[i]), 32'(mon_e.t));
            chk($sformatf("u%0d_cmd%0d_latency", i, mon_e.id), 32'(cyc - acc[i]), 32'(mon_e.lat));
            chk($sformatf("u%0d_cmd%0d_loads", i, mon_e.id), 32'(nld[i]), 32'(mon_e.nld));
          end
        end
      end
    end
  end

  task automatic preload(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    pre_v[i][0] = a;
    pre_v[i][1] = b;
    pre_v[i][2] = c;
    pre_en[i]   = 1'b1;
    @(posedge clk); #1;
    pre_en[i]   = 1'b0;
  endtask

  // Present a command and wait for its accept edge; returns 1 time unit into cycle 1.
  task automatic send(input int i, input int id, input logic [1:0] op, input logic [1:0] src,
                      input logic [1:0] dst, input logic push, input logic keep,
                      input logic e_err, input logic [W-1:0] ea, input logic [W-1:0] eb,
                      input logic [W-1:0] ec, input logic [W-1:0] et);
    logic r;
    int   t;
    exp_t e;
    cmd_valid[i] = 1'b1;
    cmd_op[i]    = op;
    cmd_src[i]   = src;
    cmd_dst[i]   = dst;
    t = 0;
    do begin
      r = cmd_ready[i];
      @(posedge clk); #1;
      t++;
    end while (!r && t < 200);
    if (!r) begin
      chk($sformatf("u%0d_cmd%0d_accept_timeout", i, id), 32'(r), 32'd1);
    end else if (push) begin
      e.id = id; e.e_err = e_err; e.a = ea; e.b = eb; e.c = ec; e.t = et;
      e.lat = lat_of(i, op, e_err);
      e.nld = e_err ? 0 : ((op == SWAP) ? 2 : 1);
      if (i == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    if (!keep) cmd_valid[i] = 1'b0;
  endtask

  // Wait until the instance is idle with nothing outstanding, bounded.
  task automatic drain(input int i);
    int t;
    t = 0;
    while (((i == 0) ? sb0.size() : sb1.size()) != 0 || !cmd_ready[i]) begin
      @(posedge clk); #1;
      t++;
      if (t > 300) begin
        chk($sformatf("u%0d_drain_timeout", i), 32'(t), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = 2'd0;
      cmd_src[i]   = 2'd0;
      cmd_dst[i]   = 2'd0;
      pre_en[i]    = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_rst_bus_sel", i), 32'(bus_sel[i]), 32'd0);
      chk($sformatf("u%0d_rst_load_en", i), 32'(load_en[i]), 32'd0);
      chk($sformatf("u%0d_rst_in_sel", i), 32'(in_sel[i]), 32'd1);
      chk($sformatf("u%0d_rst_tmp", i), 32'(tmp_q[i]), 32'd0);
      chk($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("u%0d_rst_done", i), 32'(done[i]), 32'd0);
      chk($sformatf("u%0d_rst_err", i), 32'(err[i]), 32'd0);
      chk($sformatf("u%0d_rst_cmd_ready", i), 32'(cmd_ready[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("release_ready_low", 32'(cmd_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("u0_ready_after_release", 32'(cmd_ready[0]), 32'd1);
    chk("u1_ready_after_release", 32'(cmd_ready[1]), 32'd1);

    // MOVE B->A with A=3, B=9.
    preload(0, 4'h3, 4'h9, 4'h0);
    send(0, 1, MOVE, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 4'h9, 4'h9, 4'h0, 4'h0);
    chk("move_c1_bus_sel", 32'(bus_sel[0]), 32'd1);
    chk("move_c1_load_en", 32'(load_en[0]), 32'd0);
    chk("move_c1_busy", 32'(busy[0]), 32'd1);
    @(posedge clk); #1;
    chk("move_c2_bus_sel", 32'(bus_sel[0]), 32'd1);
    chk("move_c2_load_en", 32'(load_en[0]), 32'd1);
    @(posedge clk); #1;
    chk("move_c3_done", 32'(done[0]), 32'd1);
    chk("move_c3_load_en", 32'(load_en[0]), 32'd0);
    chk("move_c3_busy", 32'(busy[0]), 32'd1);
    @(posedge clk); #1;
    chk("move_c4_busy", 32'(busy[0]), 32'd0);
    chk("move_c4_ready", 32'(cmd_ready[0]), 32'd1);
    drain(0);

    // SWAP A<->C with A=5, C=A.
    preload(0, 4'h5, 4'h7, 4'hA);
    send(0, 2, SWAP, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 4'hA, 4'h7, 4'h5, 4'h5);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("swap_c%0d_bus_sel", k + 1), 32'(bus_sel[0]), 32'(exp_bs[k]));
      chk($sformatf("swap_c%0d_load_en", k + 1), 32'(load_en[0]), 32'(exp_le[k]));
      if (k == 2) chk("swap_tmp_after_capture", 32'(tmp_q[0]), 32'h5);
      @(posedge clk); #1;
    end
    chk("swap_c7_done", 32'(done[0]), 32'd1);
    drain(0);

    // Rejects: registers and tmp (5) must be untouched.
    send(0, 3, MOVE, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 4'hA, 4'h7, 4'h5, 4'h5);
    chk("rej_move_c1_done", 32'(done[0]), 32'd1);
    chk("rej_move_c1_err", 32'(err[0]), 32'd1);
    chk("rej_move_c1_load_en", 32'(load_en[0]), 32'd0);
    drain(0);
    send(0, 4, SWAP, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 4'hA, 4'h7, 4'h5, 4'h5);
    chk("rej_swap_c1_err", 32'(err[0]), 32'd1);
    drain(0);
    send(0, 5, SWAP, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 4'hA, 4'h7, 4'h5, 4'h5);
    drain(0);

    // CLEAR B (B=F), then STEP B via the increment path.
    preload(0, 4'h1, 4'hF, 4'h2);
    send(0, 6, CLEAR, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 4'h2, 4'h0);
    chk("clear_c1_tmp_zero", 32'(tmp_q[0]), 32'd0);
    chk("clear_c1_bus_sel", 32'(bus_sel[0]), 32'd3);
    @(posedge clk); #1;
    chk("clear_c2_load_en", 32'(load_en[0]), 32'd2);
    chk("clear_c2_in_sel", 32'(in_sel[0]), 32'd1);
    drain(0);
    send(0, 7, STEP, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h2, 4'h0);
    chk("step_c1_in_sel", 32'(in_sel[0]), 32'd1);
    chk("step_c1_bus_sel", 32'(bus_sel[0]), 32'd1);
    @(posedge clk); #1;
    chk("step_c2_in_sel", 32'(in_sel[0]), 32'd0);
    chk("step_c2_load_en", 32'(load_en[0]), 32'd2);
    @(posedge clk); #1;
    chk("step_c3_in_sel", 32'(in_sel[0]), 32'd1);
    drain(0);

    // Reset during step 2 SEL of a SWAP.
    preload(0, 4'h6, 4'h3, 4'h5);
    send(0, 8, SWAP, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_tmp_captured", 32'(tmp_q[0]), 32'h6);
    rst_n = 1'b0;
    #1;
    chk("abort_load_en", 32'(load_en[0]), 32'd0);
    chk("abort_tmp_cleared", 32'(tmp_q[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_hold_load_en", 32'(load_en[0]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after_release", 32'(cmd_ready[0]), 32'd1);
    repeat (6) begin
      chk("abort_no_late_load", 32'(load_en[0]), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_A_kept", 32'(rf[0][0]), 32'h6);
    chk("abort_B_kept", 32'(rf[0][1]), 32'h3);

    // SETTLE=3 instance: four MOVEs with cmd_valid held high.
    preload(1, 4'h1, 4'h2, 4'h3);
    send(1, 11, MOVE, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h1, 4'h3, 4'h0);
    send(1, 12, MOVE, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 4'h3, 4'h1, 4'h3, 4'h0);
    send(1, 13, MOVE, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 4'h3, 4'h1, 4'h1, 4'h0);
    send(1, 14, MOVE, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h1, 4'h1, 4'h0);
    drain(1);
    drain(0);

    chk("u0_accept_count", 32'(n_acc[0]), 32'd8);
    chk("u0_done_count", 32'(n_done[0]), 32'd7);
    chk("u1_accept_count", 32'(n_acc[1]), 32'd4);
    chk("u1_done_count", 32'(n_done[1]), 32'd4);
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
